// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register-file write port, with a RAW scoreboard.
// Optional macro WB_FIXED_PRIO_EN: req1 wins every contended cycle instead of round-robin.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [IW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [IW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            mark_valid,
  input  logic [IW-1:0]   mark_rd,
  input  logic [IW-1:0]   query_ra,
  input  logic [IW-1:0]   query_rb,
  output logic            busy_a,
  output logic            busy_b,
  output logic            wb_we,
  output logic [IW-1:0]   wb_rw,
  output logic [XLEN-1:0] wb_busw,
  output logic [NREG-1:0] pending
);

  localparam logic [IW-1:0] RD_ZERO = {IW{1'b0}};

  logic            grant0_s;
  logic            grant1_s;
  logic            xfer_s;
  logic [IW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;

  logic            wb_we_q,   wb_we_d;
  logic [IW-1:0]   wb_rw_q,   wb_rw_d;
  logic [XLEN-1:0] wb_busw_q, wb_busw_d;
  logic [NREG-1:0] pending_q, pending_d;
`ifndef WB_FIXED_PRIO_EN
  logic            last_grant_q, last_grant_d;  // 1: req1 was granted last
`endif

  // Grant selection: single valid wins outright; contention resolved by policy
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: grant0_s = 1'b1;
      2'b10: grant1_s = 1'b1;
      2'b11: begin
`ifdef WB_FIXED_PRIO_EN
        grant1_s = 1'b1;
`else
        if (last_grant_q) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
`endif
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  assign xfer_s     = grant0_s | grant1_s;
  assign sel_rd_s   = grant1_s ? req1_rd   : req0_rd;
  assign sel_data_s = grant1_s ? req1_data : req0_data;

  // Next-state for the writeback stage, arbitration history and scoreboard
  always_comb begin
    wb_we_d = xfer_s && (sel_rd_s != RD_ZERO);
    if (wb_we_d) begin
      wb_rw_d   = sel_rd_s;
      wb_busw_d = sel_data_s;
    end else begin
      wb_rw_d   = wb_rw_q;
      wb_busw_d = wb_busw_q;
    end
`ifndef WB_FIXED_PRIO_EN
    if (xfer_s) begin
      last_grant_d = grant1_s;
    end else begin
      last_grant_d = last_grant_q;
    end
`endif
    // Clear first so a same-edge reservation of the same register survives
    pending_d = pending_q;
    if (wb_we_q) begin
      pending_d[wb_rw_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (mark_valid && (mark_rd != RD_ZERO)) begin
      pending_d[mark_rd] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q      <= 1'b0;
      wb_rw_q      <= RD_ZERO;
      wb_busw_q    <= {XLEN{1'b0}};
      pending_q    <= {NREG{1'b0}};
`ifndef WB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      wb_we_q      <= wb_we_d;
      wb_rw_q      <= wb_rw_d;
      wb_busw_q    <= wb_busw_d;
      pending_q    <= pending_d;
`ifndef WB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign busy_a     = (query_ra != RD_ZERO) && pending_q[query_ra];
  assign busy_b     = (query_rb != RD_ZERO) && pending_q[query_rb];
  assign wb_we      = wb_we_q;
  assign wb_rw      = wb_rw_q;
  assign wb_busw    = wb_busw_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; writebacks are checked against a queue of accepted transfers.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd, mark_rd, query_ra, query_rb, wb_rw;
  logic [31:0] req0_data, req1_data, wb_busw, pending;
  logic        mark_valid, busy_a, busy_b, wb_we;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .mark_valid(mark_valid), .mark_rd(mark_rd),
    .query_ra(query_ra), .query_rb(query_rb), .busy_a(busy_a), .busy_b(busy_b),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_busw(wb_busw), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare last cycle's accepted write, then push this cycle's transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_we", {31'd0, wb_we}, 32'd0);
    end else begin
      chk("one_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (exp_q.size() > 0) begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_we", {31'd0, wb_we}, 32'd1);
        chk("wb_rw", {27'd0, wb_rw}, {27'd0, e.rd});
        chk("wb_busw", wb_busw, e.data);
      end else begin
        chk("wb_idle", {31'd0, wb_we}, 32'd0);
      end
      if (req0_valid && req0_ready && req0_rd != 5'd0) exp_q.push_back('{rd: req0_rd, data: req0_data});
      if (req1_valid && req1_ready && req1_rd != 5'd0) exp_q.push_back('{rd: req1_rd, data: req1_data});
    end
  end

  initial begin
    logic first_g, exp_g, last_g;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
    mark_valid = 1'b0; mark_rd = 5'd0; query_ra = 5'd0; query_rb = 5'd0;
    #12;
    chk("reset_we", {31'd0, wb_we}, 32'd0);
    chk("reset_rw", {27'd0, wb_rw}, 32'd0);
    chk("reset_busw", wb_busw, 32'd0);
    chk("reset_pending", pending, 32'd0);
    step();
    rst_n = 1'b1;

    // Single write to r5
    mark_valid = 1'b1; mark_rd = 5'd5;
    step();
    mark_valid = 1'b0;
    chk("mark5", pending, 32'h0000_0020);
    query_ra = 5'd5; query_rb = 5'd0;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    chk("busy_a5", {31'd0, busy_a}, 32'd1);
    chk("busy_b0", {31'd0, busy_b}, 32'd0);
    chk("r0_ready", {31'd0, req0_ready}, 32'd1);
    chk("r1_ready_idle", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    chk("single_we", {31'd0, wb_we}, 32'd1);
    chk("busy_inflight", {31'd0, busy_a}, 32'd1);
    step();
    chk("clear5", pending, 32'd0);
    chk("busy_a_clear", {31'd0, busy_a}, 32'd0);
    chk("hold_rw", {27'd0, wb_rw}, 32'd5);
    chk("hold_busw", wb_busw, 32'hDEAD_BEEF);

    // Write to x0 alongside a reservation of x0: both ignored
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
    mark_valid = 1'b1; mark_rd = 5'd0; query_ra = 5'd0;
    #1;
    chk("x0_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0; mark_valid = 1'b0;
    chk("x0_we", {31'd0, wb_we}, 32'd0);
    chk("x0_pending", pending, 32'd0);
    chk("x0_query", {31'd0, busy_a}, 32'd0);

    // Set/clear collision on r7
    mark_valid = 1'b1; mark_rd = 5'd7;
    step();
    mark_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7777_0007;
    step();
    req0_valid = 1'b0;
    mark_valid = 1'b1; mark_rd = 5'd7;
    chk("coll_we", {31'd0, wb_we}, 32'd1);
    step();
    mark_valid = 1'b0;
    chk("coll_keep", pending, 32'h0000_0080);

    // Reset while an accepted write to r9 is on the wb stage
    mark_valid = 1'b1; mark_rd = 5'd9;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'hA5A5_0009;
    step();
    mark_valid = 1'b0; req0_valid = 1'b0;
    chk("pre_rst_we", {31'd0, wb_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'd0, wb_we}, 32'd0);
    chk("midrst_pending", pending, 32'd0);
    step();
    rst_n = 1'b1;

    // Contention right after reset: req0 (r3) vs req1 (r4)
`ifdef WB_FIXED_PRIO_EN
    first_g = 1'b1;
`else
    first_g = 1'b0;
`endif
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_0033;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h0000_0044;
    #1;
    chk("cont1_r0", {31'd0, req0_ready}, {31'd0, ~first_g});
    chk("cont1_r1", {31'd0, req1_ready}, {31'd0, first_g});
    step();
    if (first_g) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    chk("cont2_r0", {31'd0, req0_ready}, {31'd0, first_g});
    chk("cont2_r1", {31'd0, req1_ready}, {31'd0, ~first_g});
    chk("cont2_rw", {27'd0, wb_rw}, first_g ? 32'd4 : 32'd3);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont3_rw", {27'd0, wb_rw}, first_g ? 32'd3 : 32'd4);
    last_g = ~first_g;

    // Continuous contention: winners refresh their request each cycle
    req0_valid = 1'b1; req0_rd = 5'd16; req0_data = 32'h1000_0000;
    req1_valid = 1'b1; req1_rd = 5'd20; req1_data = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_FIXED_PRIO_EN
      exp_g = 1'b1;
`else
      exp_g = ~last_g;
`endif
      #1;
      chk("rr_r0", {31'd0, req0_ready}, {31'd0, ~exp_g});
      chk("rr_r1", {31'd0, req1_ready}, {31'd0, exp_g});
      step();
      if (exp_g) begin
        req1_rd = 5'(21 + i); req1_data = 32'h2000_0001 + 32'(i);
      end else begin
        req0_rd = 5'(17 + i); req0_data = 32'h1000_0001 + 32'(i);
      end
      last_g = exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    chk("final_idle", {31'd0, wb_we}, 32'd0);
    chk("final_pending", pending, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rw/busw/we) between two writeback requesters:
  - req0: main pipeline (ALU/load).
  - req1: long-latency unit (mul/div).
- Keeps a scoreboard of destination registers with writes in flight, so issue logic can stall on RAW hazards.
- Sits between the execute/writeback units and the register file; its registered outputs drive the regfile write port directly.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; index width is log2(NREG) = 5.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  pipeline writeback request.
- req0_rd  in  5  pipeline destination register.
- req0_data  in  XLEN  pipeline writeback value.
- req0_ready  out  1  pipeline request accepted this cycle.
- req1_valid  in  1  mul/div writeback request.
- req1_rd  in  5  mul/div destination register.
- req1_data  in  XLEN  mul/div writeback value.
- req1_ready  out  1  mul/div request accepted this cycle.
- mark_valid  in  1  issue stage reserves a destination register.
- mark_rd  in  5  register to reserve.
- query_ra  in  5  source register A to check.
- query_rb  in  5  source register B to check.
- busy_a  out  1  write pending on query_ra.
- busy_b  out  1  write pending on query_rb.
- wb_we  out  1  regfile write enable (registered).
- wb_rw  out  5  regfile write index (registered).
- wb_busw  out  XLEN  regfile write data (registered).
- pending  out  NREG  scoreboard bitmap, for debug/verification.

Behaviour:
- Reset (asynchronous, rst_n=0): wb_we=0, wb_rw=0, wb_busw=0, pending=0, last_grant=1.
  - Consequence: when both requesters are valid on the first contended cycle after reset, req0 wins.
  - Reset asserted mid-operation discards any accepted-but-unwritten request; no write is issued for it.
- Handshake:
  - reqN_ready is combinational and is asserted only for the granted requester.
  - A transfer completes when reqN_valid && reqN_ready.
  - A requester keeps valid, rd and data stable until it sees ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester other than last_grant (round-robin).
  - Neither valid: no grant.
  - last_grant updates only on a completed transfer.
  - Every cycle with at least one valid request produces exactly one grant, so there are no idle cycles while a request is pending.
- Writeback latency: a transfer accepted in cycle N appears on the outputs in cycle N+1 as wb_we=1, wb_rw=rd, wb_busw=data.
  - The regfile captures it at the end of cycle N+1.
  - With no transfer in cycle N, wb_we=0 in N+1; wb_rw and wb_busw hold their previous values.
- rd = 0: the handshake completes normally, but wb_we stays 0 in N+1 and no pending bit is touched.
- Scoreboard:
  - Set: mark_valid with mark_rd != 0 sets pending[mark_rd] at the clock edge. mark_rd = 0 is ignored.
  - Clear: a cycle with wb_we=1 clears pending[wb_rw] at that cycle's closing edge, i.e. the same edge at which the regfile writes.
  - Set and clear of the same index at the same edge: the set wins and the bit stays 1, because a newer writer has been reserved.
  - Writeback to a register that is not pending: the write happens and the bit stays 0. This is legal.
- Queries: busy_a = pending[query_ra] and busy_b = pending[query_rb], combinational.
  - Query of index 0 always returns 0.
  - busy stays 1 throughout cycle N+1 while the write is still in flight, so an issuing reader never sees stale data.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority; req1 always wins when both are valid, and last_grant is unused.
  - Purpose: frees the mul/div unit quickly.
  - Risk: req0 may starve while req1 stays continuously valid.
- Undefined: round-robin as described in Behaviour (default).

Test Plan:
- Single write: reset, then mark_rd=5 → pending[5]=1. req0 rd=5, data=0xDEADBEEF in cycle N → req0_ready=1 in N; in N+1 wb_we=1, wb_rw=5, wb_busw=0xDEADBEEF, busy_a=1 for query_ra=5; pending[5]=0 after that edge.
- Contention, round-robin: req0 (rd=3) and req1 (rd=4) both held valid from reset → grant order req0, req1 on consecutive cycles; wb_rw=3, then 4; no idle cycle between them.
  - With WB_FIXED_PRIO_EN defined: order is req1, then req0.
- x0 write: req1 rd=0, data=0x1234 → req1_ready=1; wb_we stays 0 next cycle; pending unchanged.
- Set/clear collision: pending[7]=1; writeback to rd=7 reaches the wb stage while mark_valid rd=7 is asserted in the same cycle → pending[7] remains 1 after the edge.
- Reset mid-flight: accept req0 rd=9 in cycle N, pull rst_n low during N+1 → wb_we=0 and pending=0 immediately; after release, the first contended grant goes to req0.
